// File: rtl/exe_stage_pkg.sv
// exe_stage shared types: bus widths, ALU op bits, divider states.
// Divider support is built only when EXE_DIV_EN is defined.
package exe_stage_pkg;

  localparam int DS_ES_BUS_W  = 151;
  localparam int ES_MS_BUS_W  = 71;
  localparam int ES_FWD_BUS_W = 39;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  typedef struct packed {
    logic        div_en;
    logic        div_signed;
    logic        div_mod;
    logic [11:0] alu_op;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [31:0] rkd_value;
    logic        gr_we;
    logic [4:0]  dest;
    logic        mem_we;
    logic        res_from_mem;
    logic [31:0] pc;
  } ds_es_t;

  function automatic logic [31:0] neg_if(
    input logic        n,
    input logic [31:0] v
  );
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/exe_div.sv
// exe_div: 32-cycle radix-2 restoring divider.
// Signed ops divide magnitudes and fix signs on the way out.
module exe_div
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        sign,
  input  logic        ack,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_t  state;
  logic [4:0]  cnt;
  logic [31:0] q;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic [31:0] dvd;
  logic        neg_q;
  logic        neg_r;
  logic        dz;
  logic [32:0] trial;
  logic [32:0] diff;

  assign trial = {rem, q[31]};
  assign diff  = trial - {1'b0, dvs};

  // Load magnitudes on start, one shift-subtract per BUSY cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= DIV_IDLE;
      cnt   <= 5'd0;
      q     <= 32'd0;
      rem   <= 32'd0;
      dvs   <= 32'd0;
      dvd   <= 32'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: if (start) begin
          state <= DIV_BUSY;
          cnt   <= 5'd0;
          rem   <= 32'd0;
          q     <= neg_if(sign && dividend[31], dividend);
          dvs   <= neg_if(sign && divisor[31], divisor);
          dvd   <= dividend;
          neg_q <= sign && (dividend[31] ^ divisor[31]);
          neg_r <= sign && dividend[31];
          dz    <= (divisor == 32'd0);
        end
        DIV_BUSY: begin
          if (!diff[32]) begin
            rem <= diff[31:0];
            q   <= {q[30:0], 1'b1};
          end else begin
            rem <= trial[31:0];
            q   <= {q[30:0], 1'b0};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31)
            state <= DIV_DONE;
        end
        DIV_DONE: if (ack)
          state <= DIV_IDLE;
        default: state <= DIV_IDLE;
      endcase
    end
  end

  assign busy      = (state == DIV_BUSY);
  assign done      = (state == DIV_DONE);
  assign quotient  = dz ? 32'hFFFF_FFFF
                        : neg_if(neg_q, q);
  assign remainder = dz ? dvd
                        : neg_if(neg_r, rem);

endmodule

// File: rtl/exe_stage.sv
// exe_stage: pipeline execute stage (ALU, data SRAM request).
// Define EXE_DIV_EN to build the iterative divider.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    ds_to_es_valid,
  input  logic [DS_ES_BUS_W-1:0]  ds_es_bus,
  output logic                    es_allow_in,
  input  logic                    ms_allow_in,
  output logic                    es_to_ms_valid,
  output logic [ES_MS_BUS_W-1:0]  es_ms_bus,
  output logic [ES_FWD_BUS_W-1:0] es_fwd_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_we,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
);

  ds_es_t      es_r;
  logic        es_valid;
  logic        es_ready_go;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [4:0]  sh;
  logic [31:0] add_res;
  logic [31:0] alu_result;
  logic [31:0] result;

  assign es_allow_in    = !es_valid
                       || (es_ready_go && ms_allow_in);
  assign es_to_ms_valid = es_valid && es_ready_go;

  // Valid bit follows decode whenever EX can take a new op.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      es_valid <= 1'b0;
    else if (es_allow_in)
      es_valid <= ds_to_es_valid;
  end

  // Bundle only loads on a real handoff from decode.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      es_r <= '0;
    else if (ds_to_es_valid && es_allow_in)
      es_r <= ds_es_t'(ds_es_bus);
  end

  assign src1    = es_r.alu_src1;
  assign src2    = es_r.alu_src2;
  assign sh      = src2[4:0];
  assign add_res = src1 + src2;

  // One-hot ALU select.
  always_comb begin
    alu_result = 32'd0;
    unique case (1'b1)
      es_r.alu_op[ALU_ADD]:  alu_result = add_res;
      es_r.alu_op[ALU_SUB]:  alu_result = src1 - src2;
      es_r.alu_op[ALU_SLT]:  alu_result =
        {31'd0, $signed(src1) < $signed(src2)};
      es_r.alu_op[ALU_SLTU]: alu_result =
        {31'd0, src1 < src2};
      es_r.alu_op[ALU_AND]:  alu_result = src1 & src2;
      es_r.alu_op[ALU_NOR]:  alu_result = ~(src1 | src2);
      es_r.alu_op[ALU_OR]:   alu_result = src1 | src2;
      es_r.alu_op[ALU_XOR]:  alu_result = src1 ^ src2;
      es_r.alu_op[ALU_SLL]:  alu_result = src1 << sh;
      es_r.alu_op[ALU_SRL]:  alu_result = src1 >> sh;
      es_r.alu_op[ALU_SRA]:  alu_result =
        $signed(src1) >>> sh;
      es_r.alu_op[ALU_LUI]:  alu_result = src2;
      default:               alu_result = 32'd0;
    endcase
  end

`ifdef EXE_DIV_EN
  logic        div_busy;
  logic        div_done;
  logic        div_start;
  logic [31:0] div_q;
  logic [31:0] div_r;

  assign div_start = es_valid && es_r.div_en
                  && !div_busy && !div_done;

  exe_div u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .sign      (es_r.div_signed),
    .ack       (es_to_ms_valid && ms_allow_in),
    .dividend  (src1),
    .divisor   (src2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign es_ready_go = !es_r.div_en || div_done;
  assign result = !es_r.div_en ? alu_result
                : es_r.div_mod ? div_r
                : div_q;
`else
  logic unused_div;
  assign unused_div  = ^{es_r.div_en,
                         es_r.div_signed,
                         es_r.div_mod};
  assign es_ready_go = 1'b1;
  assign result      = alu_result;
`endif

  // Request only on the cycle the op hands off to MEM.
  assign data_sram_en    = es_valid
                        && (es_r.mem_we || es_r.res_from_mem)
                        && ms_allow_in;
  assign data_sram_we    = (data_sram_en && es_r.mem_we)
                         ? 4'hf : 4'h0;
  assign data_sram_addr  = add_res;
  assign data_sram_wdata = es_r.rkd_value;

  assign es_ms_bus  = {es_r.pc, es_r.gr_we, es_r.dest,
                       result, es_r.res_from_mem};
  assign es_fwd_bus = {es_r.gr_we & es_valid,
                       es_r.res_from_mem & es_valid,
                       es_r.dest, result};

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: scoreboard bench for exe_stage.
// Divider scenarios build only with EXE_DIV_EN.
module tb_exe_stage;
  import exe_stage_pkg::*;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         ds_to_es_valid = 1'b0;
  logic [150:0] ds_es_bus = '0;
  logic         ms_allow_in = 1'b1;
  logic         es_allow_in;
  logic         es_to_ms_valid;
  logic [70:0]  es_ms_bus;
  logic [38:0]  es_fwd_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int checks = 0;
  int passed = 0;
  logic [70:0] sb[$];

  exe_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_es_bus       (ds_es_bus),
    .es_allow_in     (es_allow_in),
    .ms_allow_in     (ms_allow_in),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_ms_bus       (es_ms_bus),
    .es_fwd_bus      (es_fwd_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [150:0] mk(
    input logic de, input logic ds, input logic dm,
    input int op,
    input logic [31:0] s1, input logic [31:0] s2,
    input logic [31:0] rkd,
    input logic gw, input logic [4:0] dst,
    input logic mw, input logic rfm,
    input logic [31:0] pc);
    logic [11:0] oh;
    oh = 12'd1 << op;
    return {de, ds, dm, oh, s1, s2, rkd,
            gw, dst, mw, rfm, pc};
  endfunction

  function automatic logic [70:0] exp_ms(
    input logic [31:0] pc, input logic gw,
    input logic [4:0] dst, input logic [31:0] r,
    input logic rfm);
    return {pc, gw, dst, r, rfm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_exp(output logic [70:0] e);
    if (sb.size() > 0) e = sb.pop_front();
    else e = 'x;
  endtask

  task automatic send(input logic [150:0] b,
                      input logic [70:0] e);
    int n;
    n = 0;
    ds_to_es_valid = 1'b1;
    ds_es_bus = b;
    while (!es_allow_in && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      $display("FAIL send_timeout: allow_in=%b want 1",
               es_allow_in);
    end
    sb.push_back(e);
    tick();
    ds_to_es_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (es_to_ms_valid !== 1'b0)
      $display("FAIL rst_valid: got %b want 0",
               es_to_ms_valid);
    else passed++;
    checks++;
    if (es_allow_in !== 1'b1)
      $display("FAIL rst_allow: got %b want 1",
               es_allow_in);
    else passed++;
    checks++;
    if ({data_sram_en, data_sram_we} !== 5'b0)
      $display("FAIL rst_sram: got %b/%h want 0/0",
               data_sram_en, data_sram_we);
    else passed++;
    checks++;
    if (es_fwd_bus[38:37] !== 2'b00)
      $display("FAIL rst_fwd: got %b want 00",
               es_fwd_bus[38:37]);
    else passed++;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_add();
    logic [70:0] e;
    ms_allow_in = 1'b1;
    send(mk(0, 0, 0, ALU_ADD, 32'h7, 32'h5, 32'h0,
            1, 5'd3, 0, 0, 32'h100),
         exp_ms(32'h100, 1, 5'd3, 32'hC, 0));
    checks++;
    if (es_to_ms_valid !== 1'b1 || data_sram_en !== 1'b0)
      $display("FAIL add_ctl: got v=%b en=%b want 1/0",
               es_to_ms_valid, data_sram_en);
    else passed++;
    pop_exp(e);
    checks++;
    if (es_ms_bus !== e)
      $display("FAIL add_bus: got %h want %h",
               es_ms_bus, e);
    else passed++;
    checks++;
    if (es_fwd_bus !== {1'b1, 1'b0, 5'd3, 32'hC})
      $display("FAIL add_fwd: got %h want %h", es_fwd_bus,
               {1'b1, 1'b0, 5'd3, 32'hC});
    else passed++;
    tick();
    checks++;
    if (es_to_ms_valid !== 1'b0)
      $display("FAIL add_drain: got %b want 0",
               es_to_ms_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int ops[12] = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU,
                    ALU_AND, ALU_NOR, ALU_OR, ALU_XOR,
                    ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI};
    logic [31:0] a[12] = '{32'hFFFFFFFF, 32'h5,
      32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0,
      32'hF0F0F0F0, 32'h12340000, 32'hFFFF0000,
      32'h1, 32'h80000000, 32'h80000000, 32'h1234};
    logic [31:0] b[12] = '{32'h1, 32'h7, 32'h1, 32'h1,
      32'hFF00FF00, 32'h0F0F0000, 32'h00005678,
      32'h0F0F0F0F, 32'h3F, 32'h4, 32'h4, 32'hABCDE000};
    logic [31:0] r[12] = '{32'h0, 32'hFFFFFFFE, 32'h1,
      32'h0, 32'hF000F000, 32'h00000F0F, 32'h12345678,
      32'hF0F00F0F, 32'h80000000, 32'h08000000,
      32'hF8000000, 32'hABCDE000};
    logic [70:0] e;
    logic [31:0] pc;
    ms_allow_in = 1'b1;
    ds_to_es_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      pc = 32'h200 + 32'(4 * i);
      ds_es_bus = mk(0, 0, 0, ops[i], a[i], b[i], 32'h0,
                     1, 5'(i), 0, 0, pc);
      sb.push_back(exp_ms(pc, 1, 5'(i), r[i], 0));
      tick();
      pop_exp(e);
      checks++;
      if (es_to_ms_valid !== 1'b1 || es_ms_bus !== e)
        $display("FAIL alu_op%0d: got v=%b %h want %h",
                 i, es_to_ms_valid, es_ms_bus, e);
      else passed++;
    end
    for (int i = 0; i < 8; i++) begin
      logic [31:0] x;
      logic [31:0] y;
      x = $urandom;
      y = $urandom;
      pc = 32'h300 + 32'(4 * i);
      ds_es_bus = mk(0, 0, 0, ALU_ADD, x, y, 32'h0,
                     0, 5'd9, 0, 0, pc);
      sb.push_back(exp_ms(pc, 0, 5'd9, x + y, 0));
      tick();
      pop_exp(e);
      checks++;
      if (es_ms_bus !== e)
        $display("FAIL rnd_add%0d: got %h want %h",
                 i, es_ms_bus, e);
      else passed++;
    end
    ds_to_es_valid = 1'b0;
    tick();
  endtask

  task automatic test_load();
    logic [70:0] e;
    ms_allow_in = 1'b0;
    send(mk(0, 0, 0, ALU_ADD, 32'h1000, 32'h4, 32'h0,
            1, 5'd7, 0, 1, 32'h400),
         exp_ms(32'h400, 1, 5'd7, 32'h1004, 1));
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (data_sram_en !== 1'b0 || es_allow_in !== 1'b0)
        $display("FAIL ld_stall%0d: got en=%b al=%b want 0/0",
                 i, data_sram_en, es_allow_in);
      else passed++;
      if (i < 2) tick();
    end
    tick();
    ms_allow_in = 1'b1;
    #1;
    checks++;
    if (data_sram_en !== 1'b1 || data_sram_we !== 4'h0
        || data_sram_addr !== 32'h1004)
      $display("FAIL ld_req: got en=%b we=%h a=%h want 1/0/1004",
               data_sram_en, data_sram_we, data_sram_addr);
    else passed++;
    pop_exp(e);
    checks++;
    if (es_ms_bus !== e)
      $display("FAIL ld_bus: got %h want %h", es_ms_bus, e);
    else passed++;
    checks++;
    if (es_fwd_bus[38:37] !== 2'b11)
      $display("FAIL ld_fwd: got %b want 11",
               es_fwd_bus[38:37]);
    else passed++;
    tick();
    checks++;
    if (data_sram_en !== 1'b0)
      $display("FAIL ld_after: got %b want 0", data_sram_en);
    else passed++;
  endtask

  task automatic test_store();
    logic [70:0] e;
    ms_allow_in = 1'b1;
    send(mk(0, 0, 0, ALU_ADD, 32'h2000, 32'h8,
            32'hDEADBEEF, 0, 5'd0, 1, 0, 32'h500),
         exp_ms(32'h500, 0, 5'd0, 32'h2008, 0));
    checks++;
    if (data_sram_en !== 1'b1 || data_sram_we !== 4'hf
        || data_sram_wdata !== 32'hDEADBEEF
        || data_sram_addr !== 32'h2008)
      $display("FAIL st_req: got en=%b we=%h d=%h a=%h want 1/f/deadbeef/2008",
               data_sram_en, data_sram_we,
               data_sram_wdata, data_sram_addr);
    else passed++;
    pop_exp(e);
    checks++;
    if (es_ms_bus !== e)
      $display("FAIL st_bus: got %h want %h", es_ms_bus, e);
    else passed++;
    tick();
    checks++;
    if (data_sram_en !== 1'b0 || data_sram_we !== 4'h0)
      $display("FAIL st_single: got en=%b we=%h want 0/0",
               data_sram_en, data_sram_we);
    else passed++;
  endtask

`ifdef EXE_DIV_EN
  task automatic run_div(input logic sgn, input logic md,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] r,
                         input bit stall);
    logic [70:0] e;
    int n;
    ms_allow_in = 1'b1;
    send(mk(1, sgn, md, ALU_ADD, a, b, 32'h0,
            1, 5'd5, 0, 0, 32'h600),
         exp_ms(32'h600, 1, 5'd5, r, 0));
    n = 0;
    while (!es_to_ms_valid && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 33)
      $display("FAIL div_lat: got %0d want 33", n);
    else passed++;
    if (stall) begin
      ms_allow_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick();
        checks++;
        if (es_to_ms_valid !== 1'b1
            || es_ms_bus[32:1] !== r)
          $display("FAIL div_hold%0d: got v=%b %h want 1 %h",
                   i, es_to_ms_valid, es_ms_bus[32:1], r);
        else passed++;
      end
      ms_allow_in = 1'b1;
      #1;
    end
    pop_exp(e);
    checks++;
    if (es_ms_bus !== e)
      $display("FAIL div_res %h/%h s%b m%b: got %h want %h",
               a, b, sgn, md, es_ms_bus[32:1], e[32:1]);
    else passed++;
    tick();
    checks++;
    if (es_to_ms_valid !== 1'b0)
      $display("FAIL div_drain: got %b want 0",
               es_to_ms_valid);
    else passed++;
  endtask

  task automatic test_div();
    run_div(1, 0, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 0);
    run_div(1, 1, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 1);
    run_div(0, 0, 32'h5, 32'h0, 32'hFFFFFFFF, 0);
    run_div(0, 1, 32'h5, 32'h0, 32'h5, 0);
    run_div(1, 0, 32'h80000000, 32'hFFFFFFFF,
            32'h80000000, 0);
    run_div(1, 1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 0);
    run_div(0, 0, 32'hFFFFFFFF, 32'h3, 32'h55555555, 0);
    run_div(0, 1, 32'd100, 32'd7, 32'd2, 0);
  endtask
`else
  task automatic test_div_ignored();
    logic [70:0] e;
    ms_allow_in = 1'b1;
    send(mk(1, 1, 1, ALU_SUB, 32'h9, 32'h4, 32'h0,
            1, 5'd2, 0, 0, 32'h700),
         exp_ms(32'h700, 1, 5'd2, 32'h5, 0));
    pop_exp(e);
    checks++;
    if (es_to_ms_valid !== 1'b1 || es_ms_bus !== e)
      $display("FAIL nodiv: got v=%b %h want 1 %h",
               es_to_ms_valid, es_ms_bus, e);
    else passed++;
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    logic [70:0] e;
`ifdef EXE_DIV_EN
    ms_allow_in = 1'b1;
    send(mk(1, 0, 0, ALU_ADD, 32'd99, 32'd3, 32'h0,
            1, 5'd1, 0, 0, 32'h800),
         exp_ms(32'h800, 1, 5'd1, 32'd33, 0));
    repeat (9) tick();
`else
    ms_allow_in = 1'b0;
    send(mk(0, 0, 0, ALU_ADD, 32'h40, 32'h4, 32'h0,
            1, 5'd1, 0, 1, 32'h800),
         exp_ms(32'h800, 1, 5'd1, 32'h44, 1));
    tick();
    ms_allow_in = 1'b1;
`endif
    resetn = 1'b0;
    #1;
    sb.delete();
    checks++;
    if (es_allow_in !== 1'b1 || es_to_ms_valid !== 1'b0
        || data_sram_en !== 1'b0)
      $display("FAIL mid_rst: got al=%b v=%b en=%b want 1/0/0",
               es_allow_in, es_to_ms_valid, data_sram_en);
    else passed++;
    tick();
    resetn = 1'b1;
    tick();
    send(mk(0, 0, 0, ALU_ADD, 32'h10, 32'h20, 32'h0,
            1, 5'd4, 0, 0, 32'h900),
         exp_ms(32'h900, 1, 5'd4, 32'h30, 0));
    pop_exp(e);
    checks++;
    if (es_to_ms_valid !== 1'b1 || es_ms_bus !== e)
      $display("FAIL post_rst_add: got v=%b %h want 1 %h",
               es_to_ms_valid, es_ms_bus, e);
    else passed++;
    tick();
`ifdef EXE_DIV_EN
    run_div(0, 0, 32'd99, 32'd3, 32'd33, 0);
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_load();
    test_store();
`ifdef EXE_DIV_EN
    test_div();
`else
    test_div_ignored();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage in-order pipeline, between decode and memory. Latches the decode bundle under the valid/allow-in handshake, computes the ALU result or an iterative 32-bit divide, and drives the data SRAM request whose read data the memory stage consumes one cycle later. Produces the 71-bit execute-to-memory bus and a forwarding/load-use bus for decode.

## Interface
- No parameters; bus widths are fixed by package constants.
- clk  in  1  pipeline clock
- resetn  in  1  reset, asynchronous, active-low
- ds_to_es_valid  in  1  decode holds a valid instruction
- ds_es_bus  in  151  {div_en, div_signed, div_mod, alu_op[11:0], alu_src1[31:0], alu_src2[31:0], rkd_value[31:0], gr_we, dest[4:0], mem_we, res_from_mem, pc[31:0]}, MSB first
- es_allow_in  out  1  EX can accept next cycle
- ms_allow_in  in  1  memory stage can accept
- es_to_ms_valid  out  1  EX result valid toward MEM
- es_ms_bus  out  71  {pc[70:39], gr_we[38], dest[37:33], alu_result[32:1], res_from_mem[0]}
- es_fwd_bus  out  39  {gr_we&es_valid, res_from_mem&es_valid, dest[4:0], result[31:0]}
- data_sram_en  out  1  data SRAM request
- data_sram_we  out  4  byte write enables
- data_sram_addr  out  32  byte address
- data_sram_wdata  out  32  store data

## Operation
- Handshake: es_allow_in = !es_valid || (es_ready_go && ms_allow_in); es_to_ms_valid = es_valid && es_ready_go.
- es_valid <= ds_to_es_valid when es_allow_in; bundle registers load on ds_to_es_valid && es_allow_in only.
- ALU ops (one-hot alu_op[11:0]): add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui; shift amount = alu_src2[4:0]; lui passes alu_src2.
- data_sram_addr = add result; data_sram_wdata = rkd_value; word access only.
- data_sram_en = es_valid && (mem_we || res_from_mem) && ms_allow_in (issued only on the cycle the instruction moves to MEM).
- data_sram_we = 4'hf when data_sram_en && mem_we, else 4'h0.
- Divider states: IDLE -> BUSY (start when es_valid && div_en && IDLE) -> DONE (after 32 iterations) -> IDLE on es_to_ms_valid && ms_allow_in.
- Divide result: quotient, or remainder when div_mod; signed uses magnitude divide with sign fix-up (quotient sign = XOR of operand signs, remainder sign = dividend sign).
- Divide by zero: quotient 32'hFFFFFFFF, remainder = dividend. Signed 32'h80000000 / -1: quotient 32'h80000000, remainder 0.
- result = divide result when div_en, else ALU result; feeds alu_result field and es_fwd_bus.

## Timing
- Reset: es_valid 0, divider IDLE, counter 0; hence es_to_ms_valid 0, es_allow_in 1, data_sram_en 0, data_sram_we 0, es_fwd_bus valid bits 0; data outputs don't-care.
- Non-divide: es_ready_go = 1; one cycle in EX when MEM accepts.
- Divide entering EX in cycle N: start in N, iterations N+1..N+32, es_ready_go = 1 from N+33; 34 cycles minimum.
- MEM stall while DONE: result and DONE held, no restart.
- Load in EX with ms_allow_in low: no request; request fires the cycle ms_allow_in rises, rdata returns in the following cycle in MEM.
- Reset asserted mid-divide: immediate return to IDLE, es_valid 0.

## Configuration
- EXE_DIV_EN defined: divider instantiated as above.
- Undefined: no divider; div_en/div_signed/div_mod ignored, result = ALU result, es_ready_go = 1 always.

## Structure
- Shared package: bus widths (DS_ES_BUS_W 151, ES_MS_BUS_W 71, ES_FWD_BUS_W 39), alu_op bit indices, divider state encoding.
- One sub-module: exe_div (32-cycle radix-2 restoring divider; start, signed, dividend, divisor in; busy, done, quotient, remainder out).

## Test plan
- add, src1 32'h7, src2 32'h5, ms_allow_in 1 -> next cycle es_to_ms_valid 1, alu_result 32'hC, data_sram_en 0.
- load, src1 32'h1000, src2 32'h4, ms_allow_in low 3 cycles -> data_sram_en 0 during stall, 1 with addr 32'h1004, we 4'h0 on release cycle.
- store, rkd_value 32'hDEADBEEF -> data_sram_en 1, we 4'hf, wdata 32'hDEADBEEF, single cycle.
- signed div -7/2, EXE_DIV_EN -> es_ready_go rises cycle N+33, result 32'hFFFFFFFD; mod variant 32'hFFFFFFFF.
- divu 5/0 -> quotient 32'hFFFFFFFF; modu 5/0 -> 32'h5.
- resetn low at cycle N+10 of a divide -> es_valid 0, es_allow_in 1 immediately; new add after release completes in one cycle.
